// File: rtl/al4s3b_cnt_regs.sv
`default_nettype none
// ============================================================================
// Module      : al4s3b_cnt_regs
// Description : Wishbone register slave for the 16-bit up/down event counter
//               with clear/load command, enable/direction and sticky wrap
//               error status.
// Revision    : 1.0 - initial release
// ============================================================================
module al4s3b_cnt_regs #(
    parameter int                   ADDRWIDTH                = 7,
    parameter int                   DATAWIDTH                = 32,
    parameter logic [ADDRWIDTH-1:0] FPGA_REG_ID_VALUE_ADR    = 7'h0,
    parameter logic [ADDRWIDTH-1:0] FPGA_REV_NUM_ADR         = 7'h1,
    parameter logic [ADDRWIDTH-1:0] FPGA_CNT_SET_RST_REG_ADR = 7'h2,
    parameter logic [ADDRWIDTH-1:0] FPGA_CNT_EN_REG_ADR      = 7'h3,
    parameter logic [ADDRWIDTH-1:0] FPGA_CNT_ERR_STS_ADR     = 7'h4,
    parameter logic [ADDRWIDTH-1:0] FPGA_CNT_VAL_REG_ADR     = 7'h5,
    parameter logic [15:0]          AL4S3B_DEVICE_ID         = 16'h0,
    parameter logic [31:0]          AL4S3B_REV_LEVEL         = 32'h0,
    parameter logic [31:0]          AL4S3B_DEF_REG_VALUE     = 32'hFABDEFAC
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
    input  logic                 WBs_CYC_i,
    input  logic [3:0]           WBs_BYTE_STB_i,
    input  logic                 WBs_WE_i,
    input  logic                 WBs_STB_i,
    input  logic [DATAWIDTH-1:0] WBs_DAT_i,
    output logic [DATAWIDTH-1:0] WBs_DAT_o,
    output logic                 WBs_ACK_o,
    output logic [31:0]          Device_ID_o,
    output logic [15:0]          count
);

    logic        r_ack;
    logic        r_en;
    logic        r_dir;
    logic        r_ovf;
    logic        r_unf;
    logic [15:0] r_count;
    logic [15:0] r_load_val;

    logic        w_wr;
    logic        w_sel_set_rst;
    logic        w_sel_en;
    logic        w_sel_err;
    logic        w_clr;
    logic        w_load;
    logic [15:0] w_load_val;
    logic        w_en_next;
    logic        w_dir_next;
    logic [15:0] w_count_next;
    logic        w_ovf_set;
    logic        w_unf_set;
    logic        w_ovf_next;
    logic        w_unf_next;
    logic        w_unused;

    // Commit happens on the edge where ACK rises, so a held strobe commits once.
    assign w_wr          = WBs_CYC_i & WBs_STB_i & WBs_WE_i & ~r_ack;
    assign w_sel_set_rst = (WBs_ADR_i == FPGA_CNT_SET_RST_REG_ADR);
    assign w_sel_en      = (WBs_ADR_i == FPGA_CNT_EN_REG_ADR);
    assign w_sel_err     = (WBs_ADR_i == FPGA_CNT_ERR_STS_ADR);

    assign w_clr  = w_wr & w_sel_set_rst & WBs_BYTE_STB_i[0] & WBs_DAT_i[0];
    assign w_load = w_wr & w_sel_set_rst & WBs_BYTE_STB_i[0] & WBs_DAT_i[1];

    // Lanes not strobed keep the previously written load value.
    assign w_load_val = {WBs_BYTE_STB_i[3] ? WBs_DAT_i[31:24] : r_load_val[15:8],
                         WBs_BYTE_STB_i[2] ? WBs_DAT_i[23:16] : r_load_val[7:0]};

    always_comb begin
        w_en_next  = r_en;
        w_dir_next = r_dir;
        if (w_wr && w_sel_en && WBs_BYTE_STB_i[0]) begin
            w_en_next  = WBs_DAT_i[0];
            w_dir_next = WBs_DAT_i[1];
        end
    end

    always_comb begin
        w_count_next = r_count;
        w_ovf_set    = 1'b0;
        w_unf_set    = 1'b0;
        if (w_clr) begin
            w_count_next = 16'h0000;
        end else if (w_load) begin
            w_count_next = w_load_val;
        end else if (r_en) begin
            if (r_dir) begin
                w_count_next = r_count - 16'd1;
                w_unf_set    = (r_count == 16'h0000);
            end else begin
                w_count_next = r_count + 16'd1;
                w_ovf_set    = (r_count == 16'hFFFF);
            end
        end
    end

    // A wrap on the same edge as a write-1-to-clear leaves the bit set.
    always_comb begin
        w_ovf_next = r_ovf | w_ovf_set;
        w_unf_next = r_unf | w_unf_set;
        if (w_wr && w_sel_err && WBs_BYTE_STB_i[0]) begin
            w_ovf_next = (r_ovf & ~WBs_DAT_i[0]) | w_ovf_set;
            w_unf_next = (r_unf & ~WBs_DAT_i[1]) | w_unf_set;
        end
    end

    always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
        if (WBs_RST_i) begin
            r_ack      <= 1'b0;
            r_en       <= 1'b0;
            r_dir      <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_count    <= 16'h0000;
            r_load_val <= 16'h0000;
        end else begin
            r_ack   <= WBs_CYC_i & WBs_STB_i & ~r_ack;
            r_en    <= w_en_next;
            r_dir   <= w_dir_next;
            r_ovf   <= w_ovf_next;
            r_unf   <= w_unf_next;
            r_count <= w_count_next;
            if (w_wr && w_sel_set_rst) begin
                r_load_val <= w_load_val;
            end
        end
    end

    always_comb begin
        WBs_DAT_o = AL4S3B_DEF_REG_VALUE;
        case (WBs_ADR_i)
            FPGA_REG_ID_VALUE_ADR:    WBs_DAT_o = {16'h0000, AL4S3B_DEVICE_ID};
            FPGA_REV_NUM_ADR:         WBs_DAT_o = AL4S3B_REV_LEVEL;
            FPGA_CNT_SET_RST_REG_ADR: WBs_DAT_o = 32'h0000_0000;
            FPGA_CNT_EN_REG_ADR:      WBs_DAT_o = {30'h0, r_dir, r_en};
            FPGA_CNT_ERR_STS_ADR:     WBs_DAT_o = {30'h0, r_unf, r_ovf};
            FPGA_CNT_VAL_REG_ADR:     WBs_DAT_o = {16'h0000, r_count};
            default:                  WBs_DAT_o = AL4S3B_DEF_REG_VALUE;
        endcase
    end

    assign WBs_ACK_o   = r_ack;
    assign count       = r_count;
    assign Device_ID_o = {16'h0000, AL4S3B_DEVICE_ID};

    assign w_unused = ^{WBs_DAT_i[15:2], WBs_BYTE_STB_i[1]};

endmodule
`default_nettype wire
